i_decode: RTL and testbench
===========================

Name: i_decode

Overview:
- Instruction-decode stage directly downstream of i_fetch.
- Accepts one 32-bit instruction per fetch pulse into a small FIFO and decodes the FIFO head (RV32I base plus the vector OP-V, load and store opcodes).
- Presents a registered decoded record to the issue stage under valid/ready.
- Drives the vacancy signal that fetch samples before handing over an instruction.

Parameters:
- INST_WIDTH, 32, instruction width.
- DEPTH, 2, raw-instruction FIFO entries; must be a power of two and at least 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- if_valid  in  1  one-cycle pulse from fetch; if_inst valid this cycle.
- if_inst  in  32  instruction word from fetch.
- if_vacant  out  1  high when the stage can absorb one more instruction.
- is_valid  out  1  decoded record valid.
- is_ready  in  1  issue stage accepts the record.
- is_class  out  4  instruction class (enum, see Decomposition).
- is_rd, is_rs1, is_rs2  out  5 each  register fields (vd/vs1/vs2 for vector ops).
- is_funct3  out  3  funct3 field.
- is_funct7  out  7  funct7; for vector ops, {funct6, vm}.
- is_imm  out  32  sign-extended immediate; 0 for classes with no immediate.
- is_branch  out  1  class is BRANCH (fetch stalls on BNE awaiting offset).
- err_overflow  out  1  sticky flag: an if_valid arrived while the FIFO was full.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FIFO emptied, pointers and count cleared.
  - is_valid=0, all is_* fields 0, err_overflow=0.
  - if_vacant=1 from the first cycle after reset.
  - Reset mid-operation discards all buffered and presented instructions.
- Enqueue:
  - if_valid=1 with count<DEPTH: write if_inst at the write pointer; the pointer wraps modulo DEPTH.
  - if_valid=1 with count==DEPTH: drop the word, set err_overflow, leave FIFO and count unchanged.
- Vacancy:
  - if_vacant = (count < DEPTH), combinational from registered count.
  - Fetch issues at most one pulse per 3 cycles, so a vacancy seen one cycle earlier guarantees space.
- Output register:
  - Loads when (!is_valid || is_ready) and the FIFO is non-empty: the decoded head is latched, the head is popped, is_valid=1.
  - Clears is_valid when is_ready=1 and the FIFO is empty.
  - While is_valid=1 && is_ready=0, all is_* outputs hold stable.
- Simultaneous enqueue and pop in one cycle: count unchanged. This is legal when full: the pop frees a slot but the enqueue is still judged against count before the pop, so it overflows.
- Latency: if_valid in cycle t with FIFO empty and output free gives is_valid=1 in cycle t+2.
- Throughput: one record per cycle while the FIFO is non-empty and is_ready=1.
- Decode of the head, by opcode [6:0]:
  - 0110011 ALU_R
  - 0010011 ALU_I, I-immediate
  - 0000011 LOAD, I-immediate
  - 0100011 STORE, S-immediate
  - 1100011 BRANCH, B-immediate with bit0=0
  - 1101111 JAL, J-immediate
  - 1100111 JALR, I-immediate
  - 0110111 LUI, {inst[31:12], 12'b0}
  - 0010111 AUIPC, same immediate as LUI
  - 1110011 SYSTEM, I-immediate
  - 1010111 VEC_ARITH: imm = sign-extended inst[19:15] when funct3=011 (OPIVI), else 0
  - 0000111 VEC_LOAD, imm 0
  - 0100111 VEC_STORE, imm 0
  - anything else, or inst[1:0]!=11: ILLEGAL, fields still extracted raw, imm 0.
- Immediate rule: all immediates are sign-extended from inst[31] (OPIVI from inst[19]) to 32 bits.
- ILLEGAL records are forwarded, not dropped; trapping is the issue stage's job.

Decomposition:
- Shared package decode_pkg holds:
  - opcode localparams;
  - is_class enum: ALU_R=0, ALU_I=1, LOAD=2, STORE=3, BRANCH=4, JAL=5, JALR=6, LUI=7, AUIPC=8, SYSTEM=9, VEC_ARITH=10, VEC_LOAD=11, VEC_STORE=12, ILLEGAL=15;
  - the decoded-record struct.
- One combinational sub-module, inst_decoder: 32-bit word in, record out. The FIFO and output register stay in i_decode.

Test Plan:
- Reset, then if_valid with 0x00500093 (addi x1,x0,5), is_ready=1 -> 2 cycles later is_valid=1 with class=ALU_I, rd=1, rs1=0, imm=0x00000005; is_valid drops the next cycle.
- 0xFE209CE3 (bne x1,x2,-8) -> class=BRANCH, is_branch=1, rs1=1, rs2=2, funct3=001, imm=0xFFFFFFF8.
- 0x123452B7 (lui x5,0x12345) then 0x022180D7 (vadd.vv v1,v2,v3) -> LUI with rd=5, imm=0x12345000; then VEC_ARITH with rd=1, rs1=3, rs2=2, funct7=0000001, imm=0.
- is_ready=0 and three instructions pushed, pulses 3 cycles apart -> first is held on the outputs, FIFO count=2, if_vacant=0; a fourth pulse sets err_overflow=1 and is dropped. Raising is_ready then drains exactly 3 records, in order.
- 0x00000000 -> class=ILLEGAL forwarded with imm=0; rst_n=0 for one cycle with the FIFO holding 2 entries -> next cycle is_valid=0, if_vacant=1, err_overflow=0.

Source files
------------

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcodes, instruction classes and decoded-record type for i_decode
package decode_pkg;

    localparam logic [6:0] OP_ALU_R     = 7'b0110011;
    localparam logic [6:0] OP_ALU_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_LUI       = 7'b0110111;
    localparam logic [6:0] OP_AUIPC     = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OP_VEC_ARITH = 7'b1010111;
    localparam logic [6:0] OP_VEC_LOAD  = 7'b0000111;
    localparam logic [6:0] OP_VEC_STORE = 7'b0100111;

    localparam logic [2:0] F3_OPIVI = 3'b011;

    typedef enum logic [3:0] {
        CLS_ALU_R     = 4'd0,
        CLS_ALU_I     = 4'd1,
        CLS_LOAD      = 4'd2,
        CLS_STORE     = 4'd3,
        CLS_BRANCH    = 4'd4,
        CLS_JAL       = 4'd5,
        CLS_JALR      = 4'd6,
        CLS_LUI       = 4'd7,
        CLS_AUIPC     = 4'd8,
        CLS_SYSTEM    = 4'd9,
        CLS_VEC_ARITH = 4'd10,
        CLS_VEC_LOAD  = 4'd11,
        CLS_VEC_STORE = 4'd12,
        CLS_ILLEGAL   = 4'd15
    } is_class_e;

    typedef struct packed {
        is_class_e   cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        branch;
    } dec_rec_t;

endpackage

// File: rtl/i_decode_if.sv
// rtl/i_decode_if.sv - fetch-side and issue-side signals of the decode stage
interface i_decode_if #(
    parameter int INST_WIDTH = 32
);
    logic                  if_valid;
    logic [INST_WIDTH-1:0] if_inst;
    logic                  if_vacant;
    logic                  is_valid;
    logic                  is_ready;
    logic [3:0]            is_class;
    logic [4:0]            is_rd;
    logic [4:0]            is_rs1;
    logic [4:0]            is_rs2;
    logic [2:0]            is_funct3;
    logic [6:0]            is_funct7;
    logic [31:0]           is_imm;
    logic                  is_branch;
    logic                  err_overflow;

    modport master (
        output if_valid, if_inst, is_ready,
        input  if_vacant, is_valid, is_class, is_rd, is_rs1, is_rs2,
               is_funct3, is_funct7, is_imm, is_branch, err_overflow
    );

    modport slave (
        input  if_valid, if_inst, is_ready,
        output if_vacant, is_valid, is_class, is_rd, is_rs1, is_rs2,
               is_funct3, is_funct7, is_imm, is_branch, err_overflow
    );
endinterface

// File: rtl/i_decode_inst_decoder.sv
// rtl/i_decode_inst_decoder.sv - combinational RV32I + vector opcode decoder
module inst_decoder
    import decode_pkg::*;
(
    input  logic [31:0] inst_i,
    output dec_rec_t    rec_o
);

    always_comb begin
        rec_o.cls    = CLS_ILLEGAL;
        rec_o.rd     = inst_i[11:7];
        rec_o.rs1    = inst_i[19:15];
        rec_o.rs2    = inst_i[24:20];
        rec_o.funct3 = inst_i[14:12];
        rec_o.funct7 = inst_i[31:25];
        rec_o.imm    = '0;
        rec_o.branch = 1'b0;
        // Opcode includes inst[1:0], so non-32-bit encodings fall through to ILLEGAL.
        case (inst_i[6:0])
            OP_ALU_R:     rec_o.cls = CLS_ALU_R;
            OP_ALU_I: begin
                rec_o.cls = CLS_ALU_I;
                rec_o.imm = {{21{inst_i[31]}}, inst_i[30:20]};
            end
            OP_LOAD: begin
                rec_o.cls = CLS_LOAD;
                rec_o.imm = {{21{inst_i[31]}}, inst_i[30:20]};
            end
            OP_STORE: begin
                rec_o.cls = CLS_STORE;
                rec_o.imm = {{21{inst_i[31]}}, inst_i[30:25], inst_i[11:7]};
            end
            OP_BRANCH: begin
                rec_o.cls    = CLS_BRANCH;
                rec_o.branch = 1'b1;
                rec_o.imm    = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
            end
            OP_JAL: begin
                rec_o.cls = CLS_JAL;
                rec_o.imm = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
            end
            OP_JALR: begin
                rec_o.cls = CLS_JALR;
                rec_o.imm = {{21{inst_i[31]}}, inst_i[30:20]};
            end
            OP_LUI: begin
                rec_o.cls = CLS_LUI;
                rec_o.imm = {inst_i[31:12], 12'b0};
            end
            OP_AUIPC: begin
                rec_o.cls = CLS_AUIPC;
                rec_o.imm = {inst_i[31:12], 12'b0};
            end
            OP_SYSTEM: begin
                rec_o.cls = CLS_SYSTEM;
                rec_o.imm = {{21{inst_i[31]}}, inst_i[30:20]};
            end
            OP_VEC_ARITH: begin
                rec_o.cls = CLS_VEC_ARITH;
                if (inst_i[14:12] == F3_OPIVI) begin
                    rec_o.imm = {{27{inst_i[19]}}, inst_i[19:15]};
                end
            end
            OP_VEC_LOAD:  rec_o.cls = CLS_VEC_LOAD;
            OP_VEC_STORE: rec_o.cls = CLS_VEC_STORE;
            default:      rec_o.cls = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/i_decode.sv
// rtl/i_decode.sv - decode stage: raw-instruction FIFO, decoder and registered issue record
module i_decode
    import decode_pkg::*;
#(
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    i_decode_if.slave   bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [INST_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    dec_rec_t              rec_q;
    logic                  valid_q;
    logic                  err_q;

    logic     full;
    logic     push;
    logic     pop;
    dec_rec_t head_rec;

    inst_decoder u_inst_decoder (
        .inst_i (mem_q[rd_ptr_q]),
        .rec_o  (head_rec)
    );

    // Overflow is judged against the pre-pop count even if a pop frees a slot.
    assign full = (count_q == FULL_CNT);
    assign push = bus.if_valid && !full;
    assign pop  = (!valid_q || bus.is_ready) && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.if_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rec_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (bus.if_valid && full) begin
                err_q <= 1'b1;
            end
            if (pop) begin
                rec_q    <= head_rec;
                rd_ptr_q <= rd_ptr_q + 1'b1;
                valid_q  <= 1'b1;
            end else if (bus.is_ready) begin
                valid_q  <= 1'b0;
            end
        end
    end

    assign bus.if_vacant    = !full;
    assign bus.is_valid     = valid_q;
    assign bus.is_class     = rec_q.cls;
    assign bus.is_rd        = rec_q.rd;
    assign bus.is_rs1       = rec_q.rs1;
    assign bus.is_rs2       = rec_q.rs2;
    assign bus.is_funct3    = rec_q.funct3;
    assign bus.is_funct7    = rec_q.funct7;
    assign bus.is_imm       = rec_q.imm;
    assign bus.is_branch    = rec_q.branch;
    assign bus.err_overflow = err_q;

endmodule

// File: tb/tb_i_decode.sv
// tb/tb_i_decode.sv - scoreboard bench for i_decode with a reference decode model
module tb_i_decode;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i_decode_if #(.INST_WIDTH(32)) bus ();

    i_decode #(.INST_WIDTH(32), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          pops = 0;
    bit          rnd_mode = 1'b0;
    logic [31:0] expq [$];

    function automatic int sx(input int v, input int bits);
        if (v >= (1 << (bits - 1))) return v - (1 << bits);
        return v;
    endfunction

    // Expected record: {class, rd, rs1, rs2, funct3, funct7, imm, branch}
    function automatic logic [61:0] model(input logic [31:0] i);
        int          cls;
        logic [31:0] immv;
        cls  = 15;
        immv = 32'h0;
        case (i[6:0])
            7'h33: cls = 0;
            7'h13: begin cls = 1; immv = sx(int'(i[31:20]), 12); end
            7'h03: begin cls = 2; immv = sx(int'(i[31:20]), 12); end
            7'h23: begin cls = 3; immv = sx(int'(i[31:25]) * 32 + int'(i[11:7]), 12); end
            7'h63: begin
                cls  = 4;
                immv = sx(int'(i[31]) * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32
                          + int'(i[11:8]) * 2, 13);
            end
            7'h6F: begin
                cls  = 5;
                immv = sx(int'(i[31]) * (1 << 20) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048
                          + int'(i[30:21]) * 2, 21);
            end
            7'h67: begin cls = 6; immv = sx(int'(i[31:20]), 12); end
            7'h37: begin cls = 7; immv = 32'(i[31:12]) << 12; end
            7'h17: begin cls = 8; immv = 32'(i[31:12]) << 12; end
            7'h73: begin cls = 9; immv = sx(int'(i[31:20]), 12); end
            7'h57: begin
                cls = 10;
                if (i[14:12] == 3'd3) immv = sx(int'(i[19:15]), 5);
            end
            7'h07: cls = 11;
            7'h27: cls = 12;
            default: cls = 15;
        endcase
        return {4'(cls), i[11:7], i[19:15], i[24:20], i[14:12], i[31:25], immv, cls == 4};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [61:0] actual_rec();
        return {bus.is_class, bus.is_rd, bus.is_rs1, bus.is_rs2, bus.is_funct3,
                bus.is_funct7, bus.is_imm, bus.is_branch};
    endfunction

    // Monitor: every presented record must equal the scoreboard head; pop on handshake.
    always @(negedge clk) begin
        if (rst_n && bus.is_valid) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_record actual=%h expected=none", actual_rec());
            end else begin
                if (actual_rec() !== model(expq[0])) begin
                    errors++;
                    $display("FAIL record inst=%h actual=%h expected=%h",
                             expq[0], actual_rec(), model(expq[0]));
                end
                if (bus.is_ready) begin
                    void'(expq.pop_front());
                    pops++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_mode) bus.is_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push(input logic [31:0] w, input bit accept);
        bus.if_valid = 1'b1;
        bus.if_inst  = w;
        if (accept) expq.push_back(w);
        tick();
        bus.if_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic push_when_vacant(input logic [31:0] w);
        int n = 0;
        while (!bus.if_vacant && n < 50) begin
            tick();
            n++;
        end
        check("vacancy_timeout", 64'(n < 50), 64'(1));
        push(w, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain_left", 64'(expq.size()), 64'(0));
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [13];
        int         k;
        logic [31:0] w;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67,
                7'h37, 7'h17, 7'h73, 7'h57, 7'h07, 7'h27};
        k = $urandom_range(0, 13);
        w = $urandom;
        if (k < 13) w[6:0] = ops[k];
        return w;
    endfunction

    initial begin
        bus.if_valid = 1'b0;
        bus.if_inst  = 32'h0;
        bus.is_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        check("rst_valid", 64'(bus.is_valid), 64'(0));
        check("rst_fields", 64'(actual_rec()), 64'(0));
        check("rst_vacant", 64'(bus.if_vacant), 64'(1));
        check("rst_err", 64'(bus.err_overflow), 64'(0));

        // addi x1,x0,5: two-cycle latency, one-cycle presentation
        bus.is_ready = 1'b1;
        bus.if_valid = 1'b1;
        bus.if_inst  = 32'h00500093;
        expq.push_back(32'h00500093);
        tick();
        bus.if_valid = 1'b0;
        check("lat_t1_valid", 64'(bus.is_valid), 64'(0));
        tick();
        check("lat_t2_valid", 64'(bus.is_valid), 64'(1));
        check("addi_class", 64'(bus.is_class), 64'(1));
        check("addi_imm", 64'(bus.is_imm), 64'h5);
        tick();
        check("addi_drop", 64'(bus.is_valid), 64'(0));

        push(32'hFE209CE3, 1'b1);
        push(32'h123452B7, 1'b1);
        push(32'h022180D7, 1'b1);
        drain();

        // Randomized traffic with a stalling issue stage
        rnd_mode = 1'b1;
        for (int n = 0; n < 60; n++) push_when_vacant(rand_inst());
        rnd_mode = 1'b0;
        bus.is_ready = 1'b1;
        drain();
        check("rand_no_ovf", 64'(bus.err_overflow), 64'(0));

        // Fill with issue stalled, then overflow
        repeat (3) tick();
        bus.is_ready = 1'b0;
        push(32'h00100113, 1'b1);
        push(32'h00C12183, 1'b1);
        push(32'h0041A223, 1'b1);
        check("full_vacant", 64'(bus.if_vacant), 64'(0));
        check("full_err_clear", 64'(bus.err_overflow), 64'(0));
        push(32'h0000006F, 1'b0);
        check("ovf_err", 64'(bus.err_overflow), 64'(1));
        check("ovf_vacant", 64'(bus.if_vacant), 64'(0));
        pops = 0;
        bus.is_ready = 1'b1;
        repeat (3) tick();
        check("drain_rate", 64'(pops), 64'(3));
        repeat (3) tick();
        check("drain_count", 64'(pops), 64'(3));
        check("drain_idle", 64'(bus.is_valid), 64'(0));
        check("drain_q", 64'(expq.size()), 64'(0));

        push(32'h00000000, 1'b1);
        drain();

        // Reset with a held record and two buffered entries
        bus.is_ready = 1'b0;
        push(rand_inst(), 1'b1);
        push(rand_inst(), 1'b1);
        push(rand_inst(), 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        expq.delete();
        check("mrst_valid", 64'(bus.is_valid), 64'(0));
        check("mrst_vacant", 64'(bus.if_vacant), 64'(1));
        check("mrst_err", 64'(bus.err_overflow), 64'(0));
        check("mrst_fields", 64'(actual_rec()), 64'(0));
        bus.is_ready = 1'b1;
        repeat (4) tick();
        check("mrst_stay_idle", 64'(bus.is_valid), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
